hammu_hamnhan_ip: RTL and testbench
===================================

// Module: hammu_hamnhan_ip
// PURPOSE
// AXI4-Lite slave peripheral computing P = A*B (multiplier) or P = A^B (exponent),
// chosen by a SELECT register. Software writes A, B, SELECT, then START; polls DONE; reads P.
// Sits on the SoC AXI4-Lite peripheral bus, base address 0x7C80_0000.
// PARAMETERS
// C_S_AXI_DATA_WIDTH  32  AXI data width (fixed; only 32 supported)
// C_S_AXI_ADDR_WIDTH  32  AXI address width; only ADDR[4:2] decoded
// PORTS
// S_AXI_ACLK     in   1   clock; all logic on rising edge
// S_AXI_ARESETN  in   1   reset, synchronous, active-low
// S_AXI_AWADDR   in   32  write address
// S_AXI_AWVALID  in   1   write address valid
// S_AXI_AWREADY  out  1   write address accepted
// S_AXI_WDATA    in   32  write data
// S_AXI_WSTRB    in   4   write byte enables
// S_AXI_WVALID   in   1   write data valid
// S_AXI_WREADY   out  1   write data accepted
// S_AXI_BVALID   out  1   write response valid
// S_AXI_BRESP    out  2   write response, always 2'b00 (OKAY)
// S_AXI_BREADY   in   1   master accepts write response
// S_AXI_ARADDR   in   32  read address
// S_AXI_ARVALID  in   1   read address valid
// S_AXI_ARREADY  out  1   read address accepted
// S_AXI_RDATA    out  32  read data
// S_AXI_RVALID   out  1   read data valid
// S_AXI_RRESP    out  2   read response, always 2'b00 (OKAY)
// S_AXI_RREADY   in   1   master accepts read data
// BEHAVIOUR
// Register map (offset = ADDR[4:2]*4): 0x00 A (RW), 0x04 B (RW), 0x08 SELECT (RW, bit0:
//   0=multiply, 1=exponent), 0x0C START (WO, bit0=1 launches), 0x10 P (RO),
//   0x14 DONE (RO: bit0=done, bit1=busy). Offsets 0x18-0x1C: read 0, writes ignored.
// Reset (ARESETN=0 at a clock edge): all ready/valid outputs 0, RDATA=0, A=B=SELECT=P=0,
//   done=0, busy=0; aborts any computation in progress.
// Write channel: when AWVALID&WVALID both 1 and BVALID=0, AWREADY and WREADY pulse high
//   together for exactly one cycle; register updated that edge honouring WSTRB per byte;
//   BVALID rises next cycle, held until BREADY=1, then cleared. No new write accepted while BVALID=1.
// Read channel: when ARVALID=1 and RVALID=0, ARREADY pulses one cycle; RDATA latched that
//   edge; RVALID rises next cycle, RDATA stable until RREADY=1 handshake clears RVALID.
// Read and write channels independent; may complete in the same cycle.
// START write with WDATA[0]=1 while busy=0: capture A,B,SELECT; done<=0, busy<=1.
//   START while busy=1 or WDATA[0]=0: ignored (still OKAY response).
// Multiply: P = (A*B) mod 2^32; done=1, busy=0 one cycle after START accepted.
// Exponent: square-and-multiply, one exponent bit per cycle LSB first; P = (A^B) mod 2^32;
//   A^0 = 1 (incl. 0^0). Latency = bit-length(B)+1 cycles (max 33).
// P updated only at completion; holds value until next completion. done sticky until next START.
// Writes to A/B/SELECT during busy update registers but do not affect running computation.
// TESTING
// Reset, read 0x14 -> 0x0; read 0x10 -> 0x0; BRESP/RRESP always 00.
// A=2,B=3,SELECT=0,START=1; wait 200 ns -> DONE bit0=1, P=6.
// A=2,B=3,SELECT=1,START=1 -> DONE=1, P=8; A=5,B=0,SELECT=1 -> P=1.
// A=0x10000,B=0x10000,SELECT=0 -> P=0 (wrap); A=3,B=20,SELECT=1 -> P=3486784401 (0xCFD41B91).
// Write A=0xFFFFFFFF with WSTRB=4'b0001 from A=0 -> read A = 0x000000FF.
// START during exponent run (B=0xFFFFFFFF) -> ignored, busy=1 read back; reset mid-run -> DONE=0, P=0.

Source files
------------

// File: rtl/hammu_hamnhan_ip_if.sv
// AXI4-Lite bundle for the multiply/exponent peripheral.
// The slave modport faces the peripheral and the master modport faces the bus driver.
interface hammu_hamnhan_ip_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     awaddr;
    logic                              awvalid;
    logic                              awready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     wdata;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   wstrb;
    logic                              wvalid;
    logic                              wready;
    logic                              bvalid;
    logic [1:0]                        bresp;
    logic                              bready;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     araddr;
    logic                              arvalid;
    logic                              arready;
    logic [C_S_AXI_DATA_WIDTH-1:0]     rdata;
    logic                              rvalid;
    logic [1:0]                        rresp;
    logic                              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/hammu_hamnhan_ip.sv
// AXI4-Lite peripheral: P = A*B or P = A^B mod 2^32, selected by SELECT bit0.
// The exponent is computed square-and-multiply, one exponent bit per cycle, LSB first.
//
// state  | meaning
// S_IDLE | no computation running; done shows whether the last run finished
// S_MUL  | single-cycle product, result written to P on exit
// S_EXP  | one exponent bit consumed per cycle; exit when exponent exhausted
module hammu_hamnhan_ip #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
) (
    input  logic                S_AXI_ACLK,
    input  logic                S_AXI_ARESETN,
    hammu_hamnhan_ip_if.slave   s_axi
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_EXP  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_wr_ready;
    logic        r_bvalid;
    logic        r_arready;
    logic        r_rvalid;
    logic [31:0] r_rdata;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_sel;
    logic [31:0] r_p;
    logic        r_done;

    logic [31:0] r_base;
    logic [31:0] r_exp;
    logic [31:0] r_acc;

    logic        w_wr_hs;
    logic        w_rd_hs;
    logic [2:0]  w_wr_idx;
    logic [2:0]  w_rd_idx;
    logic        w_busy;
    logic        w_start;
    logic        w_finish;
    logic [31:0] w_rd_mux;
    logic        w_unused;

    function automatic logic [31:0] f_strb_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  strb
    );
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign w_wr_hs  = r_wr_ready & s_axi.awvalid & s_axi.wvalid;
    assign w_rd_hs  = r_arready & s_axi.arvalid;
    assign w_wr_idx = s_axi.awaddr[4:2];
    assign w_rd_idx = s_axi.araddr[4:2];
    assign w_busy   = (r_state != S_IDLE);

    // A START request made while a run is in progress is acknowledged on the bus but dropped
    assign w_start  = w_wr_hs && (w_wr_idx == 3'd3) && s_axi.wstrb[0] && s_axi.wdata[0] && !w_busy;

    assign w_unused = &{1'b0, s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi.awaddr[1:0],
                        s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:5], s_axi.araddr[1:0]};

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nxt = r_sel ? S_EXP : S_MUL;
            end
            S_MUL: begin
                w_finish    = 1'b1;
                w_state_nxt = S_IDLE;
            end
            S_EXP: begin
                if (r_exp == 32'd0) begin
                    w_finish    = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (w_rd_idx)
            3'd0:    w_rd_mux = r_a;
            3'd1:    w_rd_mux = r_b;
            3'd2:    w_rd_mux = {31'd0, r_sel};
            3'd4:    w_rd_mux = r_p;
            3'd5:    w_rd_mux = {30'd0, w_busy, r_done};
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            r_state    <= S_IDLE;
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
            r_a        <= 32'd0;
            r_b        <= 32'd0;
            r_sel      <= 1'b0;
            r_p        <= 32'd0;
            r_done     <= 1'b0;
            r_base     <= 32'd0;
            r_exp      <= 32'd0;
            r_acc      <= 32'd0;
        end else begin
            r_state <= w_state_nxt;

            // Ready is a one-cycle pulse; the self-clear term prevents a second accept
            r_wr_ready <= s_axi.awvalid & s_axi.wvalid & ~r_bvalid & ~r_wr_ready;
            if (w_wr_hs) begin
                r_bvalid <= 1'b1;
                case (w_wr_idx)
                    3'd0: r_a <= f_strb_merge(r_a, s_axi.wdata, s_axi.wstrb);
                    3'd1: r_b <= f_strb_merge(r_b, s_axi.wdata, s_axi.wstrb);
                    3'd2: if (s_axi.wstrb[0]) r_sel <= s_axi.wdata[0];
                    default: ;
                endcase
            end else if (r_bvalid && s_axi.bready) begin
                r_bvalid <= 1'b0;
            end

            r_arready <= s_axi.arvalid & ~r_rvalid & ~r_arready;
            if (w_rd_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && s_axi.rready) begin
                r_rvalid <= 1'b0;
            end

            // Operands are snapshotted so later register writes cannot disturb a run
            if (w_start) begin
                r_base <= r_a;
                r_exp  <= r_b;
                r_acc  <= 32'd1;
                r_done <= 1'b0;
            end else if (r_state == S_EXP && r_exp != 32'd0) begin
                if (r_exp[0]) r_acc <= r_acc * r_base;
                r_base <= r_base * r_base;
                r_exp  <= {1'b0, r_exp[31:1]};
            end

            if (w_finish) begin
                r_p    <= (r_state == S_MUL) ? (r_base * r_exp) : r_acc;
                r_done <= 1'b1;
            end
        end
    end

    assign s_axi.awready = r_wr_ready;
    assign s_axi.wready  = r_wr_ready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = 2'b00;
    assign s_axi.arready = r_arready;
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = 2'b00;

endmodule

// File: tb/tb_hammu_hamnhan_ip.sv
// Self-checking bench for hammu_hamnhan_ip: vector table, randomized runs against a
// plain-arithmetic model, and hand sequences for strobes, ignored START and mid-run reset.
module tb_hammu_hamnhan_ip;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    hammu_hamnhan_ip_if bus ();

    hammu_hamnhan_ip dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rstn),
        .s_axi         (bus)
    );

    localparam logic [31:0] OFS_A    = 32'h7C80_0000;
    localparam logic [31:0] OFS_B    = 32'h7C80_0004;
    localparam logic [31:0] OFS_SEL  = 32'h7C80_0008;
    localparam logic [31:0] OFS_STRT = 32'h7C80_000C;
    localparam logic [31:0] OFS_P    = 32'h7C80_0010;
    localparam logic [31:0] OFS_DONE = 32'h7C80_0014;
    localparam logic [31:0] OFS_RSV  = 32'h7C80_0018;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sel;
        logic [31:0] p;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, req);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=handshake", nm);
    endtask

    // Reference: repeated multiplication, only used with small exponents
    function automatic logic [31:0] m_pow(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        r = 32'd1;
        for (longint i = 0; i < longint'(b); i++) r = r * a;
        return r;
    endfunction

    function automatic logic [31:0] m_op(input logic [31:0] a, input logic [31:0] b, input logic sel);
        return sel ? m_pow(a, b) : a * b;
    endfunction

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.awready && n < 50);
        if (!bus.awready) begin
            tmo("aw_handshake");
            bus.awvalid = 1'b0;
            bus.wvalid  = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        n = 0;
        while (!bus.bvalid && n < 50) begin @(negedge clk); n++; end
        if (!bus.bvalid) begin
            tmo("b_handshake");
            bus.bready = 1'b0;
            return;
        end
        chk("bresp", {30'd0, bus.bresp}, 32'd0);
        @(posedge clk);
        #1;
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        data = 32'hDEAD_BEEF;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.arready && n < 50);
        if (!bus.arready) begin
            tmo("ar_handshake");
            bus.arvalid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;
        n = 0;
        while (!bus.rvalid && n < 50) begin @(negedge clk); n++; end
        if (!bus.rvalid) begin
            tmo("r_handshake");
            bus.rready = 1'b0;
            return;
        end
        data = bus.rdata;
        chk("rresp", {30'd0, bus.rresp}, 32'd0);
        @(posedge clk);
        #1;
        bus.rready = 1'b0;
    endtask

    // Launch one operation and return the first DONE read plus the final P
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sel,
                          output logic [31:0] first_done, output logic [31:0] p, output int polls);
        logic [31:0] d;
        axi_write(OFS_A, a, 4'hF);
        axi_write(OFS_B, b, 4'hF);
        axi_write(OFS_SEL, {31'd0, sel}, 4'hF);
        axi_write(OFS_STRT, 32'd1, 4'hF);
        axi_read(OFS_DONE, first_done);
        d = first_done;
        polls = 1;
        while (d[0] !== 1'b1 && polls < 100) begin
            axi_read(OFS_DONE, d);
            polls++;
        end
        chk("done_final", d, 32'h1);
        axi_read(OFS_P, p);
    endtask

    vec_t        vecs[6];
    logic [31:0] rd;
    logic [31:0] fd;
    logic [31:0] p;
    int          polls;

    initial begin
        bus.awaddr = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b0;

        vecs[0] = '{a: 32'd2,        b: 32'd3,        sel: 1'b0, p: 32'd6};
        vecs[1] = '{a: 32'd2,        b: 32'd3,        sel: 1'b1, p: 32'd8};
        vecs[2] = '{a: 32'd5,        b: 32'd0,        sel: 1'b1, p: 32'd1};
        vecs[3] = '{a: 32'h0001_0000, b: 32'h0001_0000, sel: 1'b0, p: 32'd0};
        vecs[4] = '{a: 32'd3,        b: 32'd20,       sel: 1'b1, p: 32'hCFD4_1B91};
        vecs[5] = '{a: 32'd0,        b: 32'd0,        sel: 1'b1, p: 32'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {26'd0, bus.awready, bus.wready, bus.bvalid, bus.arready, bus.rvalid, 1'b0}, 32'd0);
        chk("reset_rdata", bus.rdata, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;

        axi_read(OFS_DONE, rd); chk("reset_done", rd, 32'd0);
        axi_read(OFS_P, rd);    chk("reset_p", rd, 32'd0);
        axi_read(OFS_A, rd);    chk("reset_a", rd, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sel, fd, p, polls);
            if (!vecs[i].sel) chk($sformatf("vec%0d_mul_latency", i), fd, 32'h1);
            chk($sformatf("vec%0d_p", i), p, vecs[i].p);
        end

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            logic        sel;
            a   = $urandom;
            sel = 1'($urandom_range(0, 1));
            b   = sel ? 32'($urandom_range(0, 70)) : $urandom;
            run_op(a, b, sel, fd, p, polls);
            chk($sformatf("rand%0d_p a=%08h b=%08h sel=%0d", i, a, b, sel), p, m_op(a, b, sel));
        end

        // Byte strobes
        axi_write(OFS_A, 32'd0, 4'hF);
        axi_write(OFS_A, 32'hFFFF_FFFF, 4'b0001);
        axi_read(OFS_A, rd); chk("wstrb_byte0", rd, 32'h0000_00FF);
        axi_write(OFS_A, 32'h1234_5678, 4'b0100);
        axi_read(OFS_A, rd); chk("wstrb_byte2", rd, 32'h0034_00FF);

        // Reserved offsets and write-only START read as zero
        axi_write(OFS_RSV, 32'hA5A5_A5A5, 4'hF);
        axi_read(OFS_RSV, rd);  chk("reserved_read", rd, 32'd0);
        axi_read(OFS_STRT, rd); chk("start_read", rd, 32'd0);
        axi_read(OFS_A, rd);    chk("reserved_write_ignored", rd, 32'h0034_00FF);

        // START with bit0 clear is ignored: DONE stays set from the previous run
        axi_write(OFS_STRT, 32'd0, 4'hF);
        axi_read(OFS_DONE, rd); chk("start_bit0_clear", rd, 32'h1);

        // Long exponent; 3^(2^32-1) mod 2^32 is the inverse of 3, i.e. 0xAAAAAAAB
        axi_write(OFS_A, 32'd3, 4'hF);
        axi_write(OFS_B, 32'hFFFF_FFFF, 4'hF);
        axi_write(OFS_SEL, 32'd1, 4'hF);
        axi_write(OFS_STRT, 32'd1, 4'hF);
        axi_write(OFS_A, 32'd2, 4'hF);
        axi_write(OFS_B, 32'd3, 4'hF);
        axi_write(OFS_SEL, 32'd0, 4'hF);
        axi_write(OFS_STRT, 32'd1, 4'hF);
        axi_read(OFS_DONE, rd); chk("busy_during_run", rd, 32'h2);
        axi_read(OFS_A, rd);    chk("a_written_while_busy", rd, 32'd2);
        polls = 0;
        do begin axi_read(OFS_DONE, rd); polls++; end while (rd[0] !== 1'b1 && polls < 100);
        chk("long_exp_done", rd, 32'h1);
        axi_read(OFS_P, rd); chk("long_exp_p", rd, 32'hAAAA_AAAB);

        // Reset in the middle of a long run
        axi_write(OFS_A, 32'd3, 4'hF);
        axi_write(OFS_B, 32'hFFFF_FFFF, 4'hF);
        axi_write(OFS_SEL, 32'd1, 4'hF);
        axi_write(OFS_STRT, 32'd1, 4'hF);
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        axi_read(OFS_DONE, rd); chk("midrun_reset_done", rd, 32'd0);
        axi_read(OFS_P, rd);    chk("midrun_reset_p", rd, 32'd0);
        axi_read(OFS_SEL, rd);  chk("midrun_reset_sel", rd, 32'd0);
        repeat (40) @(posedge clk);
        axi_read(OFS_DONE, rd); chk("midrun_reset_stays_idle", rd, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
